// File: rtl/intr_claim_arbiter.sv
// Slow-domain interrupt claim arbiter: latches rising edges into pending bits,
// masks them with enables and in-service state, and offers one source at a time
// through a valid/ready claim handshake using round-robin priority.
module intr_claim_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ID_W  = 3
) (
   input  logic             sync_clk,
   input  logic             sync_resetn,
   input  logic [WIDTH-1:0] intr_in,
   input  logic [WIDTH-1:0] intr_en,
   output logic             claim_valid,
   output logic [ID_W-1:0]  claim_id,
   input  logic             claim_ready,
   input  logic             complete,
   input  logic [ID_W-1:0]  complete_id,
   output logic [WIDTH-1:0] pending,
   output logic             irq_out
);

   typedef enum logic [0:0] {StIdle, StOffer} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] in_service_q, in_service_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  claim_id_q, claim_id_d;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] eligible;
   logic [WIDTH-1:0] hs_vec;
   logic [WIDTH-1:0] cmp_vec;
   logic             handshake;
   logic             load_id;
   logic             found_hi;
   logic             found_lo;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  winner_hi;
   logic [ID_W-1:0]  winner_lo;

   assign rise      = intr_in & ~prev_q;
   assign eligible  = pending_q & intr_en & ~in_service_q;
   assign handshake = claim_valid & claim_ready;

   // Round-robin pick: lowest eligible index at or above ptr, else lowest overall.
   always_comb begin
      winner_hi = '0;
      winner_lo = '0;
      found_hi  = 1'b0;
      found_lo  = 1'b0;
      for (int j = WIDTH - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            winner_lo = ID_W'(j);
            found_lo  = 1'b1;
            if (j >= int'(ptr_q)) begin
               winner_hi = ID_W'(j);
               found_hi  = 1'b1;
            end
         end
      end
      winner = found_hi ? winner_hi : (found_lo ? winner_lo : '0);
   end

   // Pending / in-service / pointer next state; new edges win over a claim clear,
   // a claim set wins over a same-cycle completion.
   always_comb begin
      hs_vec  = handshake ? (WIDTH'(1) << claim_id_q) : '0;
      cmp_vec = (complete && (32'(complete_id) < WIDTH)) ? (WIDTH'(1) << complete_id) : '0;
      pending_d    = (pending_q & ~hs_vec) | rise;
      in_service_d = (in_service_q & ~cmp_vec) | hs_vec;
      ptr_d        = ptr_q;
      if (handshake) begin
         ptr_d = (claim_id_q == ID_W'(WIDTH - 1)) ? '0 : claim_id_q + ID_W'(1);
      end
      claim_id_d = load_id ? winner : claim_id_q;
   end

   // FSM next state: an offer is held until accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (|eligible) state_d = StOffer;
         StOffer: if (claim_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: offer flag and winner capture strobe.
   always_comb begin
      claim_valid = 1'b0;
      load_id     = 1'b0;
      case (state_q)
         StIdle:  load_id = |eligible;
         StOffer: claim_valid = 1'b1;
         default: ;
      endcase
   end

   // State registers; prev resets high so lines already asserted do not fire.
   always_ff @(posedge sync_clk or negedge sync_resetn) begin
      if (!sync_resetn) begin
         state_q      <= StIdle;
         prev_q       <= '1;
         pending_q    <= '0;
         in_service_q <= '0;
         ptr_q        <= '0;
         claim_id_q   <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= intr_in;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         ptr_q        <= ptr_d;
         claim_id_q   <= claim_id_d;
      end
   end

   assign claim_id = claim_id_q;
   assign pending  = pending_q;
   assign irq_out  = claim_valid;

endmodule

// File: tb/tb_intr_claim_arbiter.sv
// Self-checking bench for intr_claim_arbiter: a behavioural model tracks the
// 8-source instance every cycle, directed literals pin key moments, and a small
// 6-source instance exercises out-of-range completion IDs.
module tb_intr_claim_arbiter;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] intr_in;
   logic [7:0] intr_en;
   logic       claim_valid;
   logic [2:0] claim_id;
   logic       claim_ready;
   logic       complete;
   logic [2:0] complete_id;
   logic [7:0] pending;
   logic       irq_out;

   logic [5:0] in6;
   logic [5:0] en6;
   logic       v6;
   logic [2:0] id6;
   logic       rdy6;
   logic       cmp6;
   logic [2:0] cid6;
   logic [5:0] p6;
   logic       irq6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   intr_claim_arbiter #(.WIDTH(8), .ID_W(3)) u_dut (
      .sync_clk    (clk),
      .sync_resetn (rst_n),
      .intr_in     (intr_in),
      .intr_en     (intr_en),
      .claim_valid (claim_valid),
      .claim_id    (claim_id),
      .claim_ready (claim_ready),
      .complete    (complete),
      .complete_id (complete_id),
      .pending     (pending),
      .irq_out     (irq_out)
   );

   intr_claim_arbiter #(.WIDTH(6), .ID_W(3)) u_dut6 (
      .sync_clk    (clk),
      .sync_resetn (rst_n),
      .intr_in     (in6),
      .intr_en     (en6),
      .claim_valid (v6),
      .claim_id    (id6),
      .claim_ready (rdy6),
      .complete    (cmp6),
      .complete_id (cid6),
      .pending     (p6),
      .irq_out     (irq6)
   );

   typedef struct packed {
      logic [7:0] prev;
      logic [7:0] pend;
      logic [7:0] insvc;
      int         ptr;
      logic       offer;
      int         id;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r      = '0;
      r.prev = 8'hFF;
      return r;
   endfunction

   // One clock of the specified behaviour, from old state and sampled inputs.
   function automatic model_t step(input model_t s, input logic [7:0] in, input logic [7:0] en,
                                   input logic rdy, input logic cmp, input logic [2:0] cid);
      model_t     n;
      logic [2:0] c;
      logic [2:0] sid;
      n   = s;
      sid = 3'(s.id);
      if (cmp && int'(cid) < W && s.insvc[cid]) n.insvc[cid] = 1'b0;
      if (s.offer) begin
         if (rdy) begin
            n.pend[sid]  = 1'b0;
            n.insvc[sid] = 1'b1;
            n.ptr        = (s.id + 1) % W;
            n.offer      = 1'b0;
         end
      end else begin
         for (int k = 0; k < W; k++) begin
            c = 3'((s.ptr + k) % W);
            if (!n.offer && s.pend[c] && en[c] && !s.insvc[c]) begin
               n.offer = 1'b1;
               n.id    = int'(c);
            end
         end
      end
      n.pend = n.pend | (in & ~s.prev);
      n.prev = in;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= step(m, intr_in, intr_en, claim_ready, complete, complete_id);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("claim_valid", 32'(claim_valid), 32'(m.offer));
      chk("irq_out", 32'(irq_out), 32'(m.offer));
      chk("pending", 32'(pending), 32'(m.pend));
      if (m.offer) chk("claim_id", 32'(claim_id), 32'(m.id));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 12; t++) begin
         if (claim_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic lit_offer(input string nm, input logic [2:0] id);
      chk({nm, " valid"}, 32'(claim_valid), 32'd1);
      chk({nm, " id"}, 32'(claim_id), 32'(id));
   endtask

   task automatic do_complete(input logic [2:0] id);
      complete    = 1'b1;
      complete_id = id;
      tick(1);
      complete    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit         ok;
      logic [2:0] ids [3];
      rst_n       = 1'b0;
      intr_in     = 8'h01;
      intr_en     = 8'hFF;
      claim_ready = 1'b0;
      complete    = 1'b0;
      complete_id = 3'd0;
      in6 = 6'h00; en6 = 6'h3F; rdy6 = 1'b0; cmp6 = 1'b0; cid6 = 3'd0;
      tick(3);
      chk("reset valid", 32'(claim_valid), 32'd0);
      chk("reset id", 32'(claim_id), 32'd0);
      chk("reset pending", 32'(pending), 32'd0);
      chk("reset irq", 32'(irq_out), 32'd0);
      rst_n = 1'b1;

      // Line high through reset release must not fire; a fresh rise must.
      tick(4);
      chk("s1 held-high pending", 32'(pending), 32'd0);
      chk("s1 held-high valid", 32'(claim_valid), 32'd0);
      intr_in = 8'h00; tick(1);
      intr_in = 8'h01; tick(1);
      chk("s1 pending after rise", 32'(pending), 32'h01);
      chk("s1 no offer yet", 32'(claim_valid), 32'd0);
      tick(1);
      lit_offer("s1 offer", 3'd0);
      claim_ready = 1'b1; tick(1); claim_ready = 1'b0;
      chk("s1 valid after hs", 32'(claim_valid), 32'd0);
      do_complete(3'd0);

      // Three simultaneous rises, ready held high.
      intr_in = 8'h53; claim_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         wait_valid(ok);
         chk("s2 offer seen", 32'(ok), 32'd1);
         ids[n] = claim_id;
         tick(1);
         do_complete(ids[n]);
      end
      claim_ready = 1'b0;
      chk("s2 first id", 32'(ids[0]), 32'd1);
      chk("s2 second id", 32'(ids[1]), 32'd4);
      chk("s2 third id", 32'(ids[2]), 32'd6);
      chk("s2 model ptr", 32'(m.ptr), 32'd7);
      tick(1);

      // Offer must stay stable while ready is low and the enable drops.
      intr_in = 8'h5B; tick(2);
      lit_offer("s3 offer", 3'd3);
      intr_en = 8'hF7;
      for (int n = 0; n < 10; n++) begin
         tick(1);
         lit_offer("s3 hold", 3'd3);
      end
      claim_ready = 1'b1; tick(1); claim_ready = 1'b0; intr_en = 8'hFF;
      chk("s3 pending cleared", 32'(pending), 32'd0);
      chk("s3 valid low", 32'(claim_valid), 32'd0);
      do_complete(3'd3);
      chk("s3 model ptr", 32'(m.ptr), 32'd4);

      // In-service source re-raises: latched but not offered until completion.
      intr_in = 8'h5F; tick(2);
      lit_offer("s4 offer", 3'd2);
      claim_ready = 1'b1; tick(1); claim_ready = 1'b0;
      intr_in = 8'h5B; tick(1);
      intr_in = 8'h5F; tick(1);
      chk("s4 pending relatched", 32'(pending), 32'h04);
      tick(3);
      chk("s4 no reoffer", 32'(claim_valid), 32'd0);
      do_complete(3'd2);
      chk("s4 not yet", 32'(claim_valid), 32'd0);
      tick(1);
      lit_offer("s4 reoffer", 3'd2);
      claim_ready = 1'b1; tick(1); claim_ready = 1'b0;
      do_complete(3'd2);

      // Edge coinciding with the handshake of the same source.
      intr_in = 8'h7F; tick(2);
      lit_offer("s5 offer", 3'd5);
      intr_in = 8'h5F; tick(1);
      intr_in = 8'h7F; claim_ready = 1'b1; tick(1); claim_ready = 1'b0;
      chk("s5 pending kept", 32'(pending), 32'h20);
      tick(3);
      chk("s5 in service blocks", 32'(claim_valid), 32'd0);
      do_complete(3'd5);
      tick(1);
      lit_offer("s5 reoffer", 3'd5);
      claim_ready = 1'b1; tick(1); claim_ready = 1'b0;
      do_complete(3'd5);
      chk("s5 model ptr", 32'(m.ptr), 32'd6);

      // Asynchronous reset during an offer drops it.
      intr_in = 8'hFF; tick(2);
      lit_offer("s6 offer", 3'd7);
      #3 rst_n = 1'b0;
      #1;
      chk("s6 async valid", 32'(claim_valid), 32'd0);
      chk("s6 async irq", 32'(irq_out), 32'd0);
      chk("s6 async id", 32'(claim_id), 32'd0);
      chk("s6 async pending", 32'(pending), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(6);
      chk("s6 no replay valid", 32'(claim_valid), 32'd0);
      chk("s6 no replay pending", 32'(pending), 32'd0);
      chk("s6 model ptr", 32'(m.ptr), 32'd0);

      // Six-source instance: completion ID 7 is out of range and ignored.
      in6 = 6'h04; tick(2);
      chk("w6 offer valid", 32'(v6), 32'd1);
      chk("w6 offer id", 32'(id6), 32'd2);
      rdy6 = 1'b1; tick(1); rdy6 = 1'b0;
      chk("w6 valid after hs", 32'(v6), 32'd0);
      cmp6 = 1'b1; cid6 = 3'd7; tick(1); cmp6 = 1'b0;
      in6 = 6'h00; tick(1);
      in6 = 6'h04; tick(1);
      chk("w6 pending relatched", 32'(p6), 32'h04);
      tick(3);
      chk("w6 id7 ignored", 32'(v6), 32'd0);
      cmp6 = 1'b1; cid6 = 3'd2; tick(1); cmp6 = 1'b0;
      tick(1);
      chk("w6 reoffer valid", 32'(v6), 32'd1);
      chk("w6 reoffer id", 32'(id6), 32'd2);
      chk("w6 irq mirrors", 32'(irq6), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/intr_claim_arbiter.md
# intr_claim_arbiter

Slow-domain interrupt controller placed directly after the fast-to-slow rising-edge interrupt synchronizer. It converts WIDTH synchronized interrupt levels into latched pending bits, masks them, and round-robin arbitrates among them. It presents one interrupt at a time to a single consumer (CPU-side interrupt unit or mailbox) through a valid/ready claim handshake, and tracks per-source in-service state until the consumer signals completion.

## Interface

- WIDTH, 8, number of interrupt sources (1..2^ID_W)
- ID_W, 3, width of source IDs; 2^ID_W >= WIDTH required

- sync_clk  in  1  sole clock, same clock as the synchronizer output
- sync_resetn  in  1  reset, asynchronous, active-low
- intr_in  in  WIDTH  synchronized interrupt levels, rising-edge meaningful
- intr_en  in  WIDTH  per-source enable mask, quasi-static configuration
- claim_valid  out  1  a claim is offered
- claim_id  out  ID_W  source ID of the offered claim
- claim_ready  in  1  consumer accepts the claim
- complete  in  1  one-cycle completion strobe
- complete_id  in  ID_W  source whose service has finished
- pending  out  WIDTH  latched pending bits, for status/debug
- irq_out  out  1  equals claim_valid

## Operation

- Edge detect: prev register holds last intr_in; edge = intr_in & ~prev. prev resets to all-ones, so a line already high when reset is released does not fire. It fires only after a 0->1 transition.
- pending[i]: set on edge[i] regardless of intr_en. Cleared on claim handshake (claim_valid & claim_ready) for i == claim_id. If the set and the clear fall in the same cycle, set wins.
- in_service[i]: set on claim handshake for i == claim_id. Cleared on complete with complete_id == i.
  - complete for a source not in service: ignored.
  - complete_id >= WIDTH: ignored.
  - complete and claim handshake on the same ID in the same cycle: in_service ends set.
- eligible = pending & intr_en & ~in_service.
- A source claimed again before completion cannot be re-offered. Its new edges latch in pending.
- Disabled sources keep pending latched and become eligible once enabled.
- Round-robin pointer ptr (ID_W bits, reset 0). Search order is ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1. On handshake, ptr = claim_id+1, wrapping WIDTH-1 -> 0.
- FSM, two states:
  - IDLE: claim_valid=0. If eligible != 0, register the winner into claim_id and go to OFFER. Otherwise stay in IDLE.
  - OFFER: claim_valid=1. claim_id is held stable and the claim is never retracted, even if intr_en or eligible changes. On claim_ready, perform the handshake updates above and return to IDLE.
- Throughput: at most one claim every 2 cycles.
- Reset values: claim_valid 0, claim_id 0, irq_out 0, pending 0, in_service 0, ptr 0, FSM IDLE, prev all-ones.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any outstanding offer is dropped, not replayed.

## Timing

- intr_in sampled high at edge k (prev 0): pending visible after k. The FSM selects at k+1. claim_valid is high after k+1, i.e. 2 cycles of latency.
- Handshake at edge h: claim_valid low after h. The next claim is at earliest valid after h+1.
- complete at edge c: the source is eligible for selection at c+1 if pending. claim_valid is at earliest valid after c+1.
- All outputs are registered except irq_out, which is a wire copy of claim_valid. pending is driven from its register.

## Test plan

- Reset release with intr_in=8'h01 held high -> no pending, claim_valid stays 0. Then drop and re-raise bit 0 -> claim_id=0 is offered exactly 2 cycles after the rise.
- intr_in bits 1, 4 and 6 rise together, intr_en=8'hFF, claim_ready always 1, complete issued after each claim -> claims in order 1, 4, 6. ptr=7 afterwards.
- Offer of ID 3 with claim_ready held 0 for 10 cycles while intr_en[3] is deasserted -> claim_valid and claim_id=3 remain stable until ready. Handshake then clears pending[3].
- Source 2 claimed and not completed, with a second rising edge on 2 -> pending[2]=1 but no offer. After complete with complete_id=2 -> ID 2 is offered 2 cycles later. complete_id=7 with WIDTH=6 -> no state change.
- Edge on bit 5 in the same cycle as the handshake of ID 5 -> pending[5] remains 1 and in_service[5]=1.
- sync_resetn pulsed low during OFFER -> all outputs are 0 immediately and pending=0. No claim follows without new edges.
